// File: rtl/systolic_pkg.sv
// Shared sizing defaults, FSM state encoding and a small width helper for the systolic operand feeder.
// Holds no logic and no state.
package systolic_pkg;

  localparam int N_DEF        = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int FEED_LEN_DEF = 3 * N_DEF - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FEED  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // $clog2 that never returns zero, so degenerate sizes still give a legal vector width
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_sel.sv
// Skewed element select for one lane: lane k at step t reads element t-k, valid while 0 <= t-k < N.
// Purely combinational; no flow control.
module skew_sel
  import systolic_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TW   = 4,
  parameter int LANE = 0,
  parameter int IW   = clog2_min1(N)
) (
  input  logic [TW-1:0] t,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [TW:0] diff;

  always_comb begin
    diff = {1'b0, t} - (TW+1)'(LANE);
    vld  = (t >= TW'(LANE)) && (diff < (TW+1)'(N));
    idx  = diff[IW-1:0];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A/B operands and streams them diagonally skewed into an NxN systolic array, one step per cycle.
// Run latency FEED_LEN+2 cycles from start to done; writes and starts are dropped while busy.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FEED_LEN = 3 * N - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              arr_rst_n,
  output logic [DATA_W-1:0] west0,
  output logic [DATA_W-1:0] west1,
  output logic [DATA_W-1:0] west2,
  output logic [DATA_W-1:0] west3,
  output logic [DATA_W-1:0] north0,
  output logic [DATA_W-1:0] north1,
  output logic [DATA_W-1:0] north2,
  output logic [DATA_W-1:0] north3
);

  localparam int TW = clog2_min1(FEED_LEN);
  localparam int IW = clog2_min1(N);
  localparam int NE = N * N;
  localparam int AW = clog2_min1(NE);
  localparam int PL = (N > 4) ? N : 4;
  localparam logic [TW-1:0] T_LAST = TW'(FEED_LEN - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              arn_q, arn_d;

  logic [DATA_W-1:0] a_q [NE];
  logic [DATA_W-1:0] a_d [NE];
  logic [DATA_W-1:0] b_q [NE];
  logic [DATA_W-1:0] b_d [NE];

  logic [DATA_W-1:0] west_q  [PL];
  logic [DATA_W-1:0] west_d  [PL];
  logic [DATA_W-1:0] north_q [PL];
  logic [DATA_W-1:0] north_d [PL];

  logic [IW-1:0]     w_idx  [N];
  logic [IW-1:0]     n_idx  [N];
  logic [N-1:0]      w_vld;
  logic [N-1:0]      n_vld;
  logic [AW-1:0]     w_addr [N];
  logic [AW-1:0]     n_addr [N];
  logic [AW-1:0]     wr_idx;
  logic              wr_ok;

  assign wr_idx = AW'(wr_addr);
  assign wr_ok  = wr_en && (state_q == ST_IDLE);

  // Lanes select with the next step so the registered operands line up with the reported t
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_sel #(.N(N), .TW(TW), .LANE(i), .IW(IW)) u_west_sel (
      .t   (t_d),
      .idx (w_idx[i]),
      .vld (w_vld[i])
    );
    skew_sel #(.N(N), .TW(TW), .LANE(i), .IW(IW)) u_north_sel (
      .t   (t_d),
      .idx (n_idx[i]),
      .vld (n_vld[i])
    );
    assign w_addr[i] = AW'(i * N) + AW'(w_idx[i]);
    assign n_addr[i] = AW'(n_idx[i]) * AW'(N) + AW'(i);
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        t_d     = '0;
      end
      ST_FEED: begin
        if (t_q == T_LAST) begin
          state_d = ST_DONE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    arn_d  = (state_d != ST_CLEAR);
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_ok && !wr_sel) a_d[wr_idx] = wr_data;
    if (wr_ok &&  wr_sel) b_d[wr_idx] = wr_data;
  end

  always_comb begin
    for (int i = 0; i < PL; i++) begin
      west_d[i]  = '0;
      north_d[i] = '0;
    end
    if (state_d == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        if (w_vld[i]) west_d[i]  = a_q[w_addr[i]];
        if (n_vld[i]) north_d[i] = b_q[n_addr[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      arn_q   <= 1'b0;
      for (int k = 0; k < NE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k < PL; k++) begin
        west_q[k]  <= '0;
        north_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      arn_q   <= arn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      west_q  <= west_d;
      north_q <= north_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign arr_rst_n = arn_q;
  assign west0     = west_q[0];
  assign west1     = west_q[1];
  assign west2     = west_q[2];
  assign west3     = west_q[3];
  assign north0    = north_q[0];
  assign north1    = north_q[1];
  assign north2    = north_q[2];
  assign north3    = north_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: per-cycle operand/status timeline plus an output-stationary
// array model fed from the DUT outputs, both compared against values derived from shadow copies of A and B.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FL = 3 * N - 2;
  localparam int RL = FL + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, arr_rst_n;
  logic [DW-1:0] west0, west1, west2, west3;
  logic [DW-1:0] north0, north1, north2, north3;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] ma [N*N];
  logic [DW-1:0] mb [N*N];
  logic [DW-1:0] rec_w [N][RL];
  logic [DW-1:0] rec_n [N][RL];

  systolic_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .arr_rst_n (arr_rst_n),
    .west0     (west0),
    .west1     (west1),
    .west2     (west2),
    .west3     (west3),
    .north0    (north0),
    .north1    (north1),
    .north2    (north2),
    .north3    (north3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] wbus();
    return {west3, west2, west1, west0};
  endfunction

  function automatic logic [127:0] nbus();
    return {north3, north2, north1, north0};
  endfunction

  // Lane i at step t carries A[i][t-i] / B[t-i][i] inside the N-wide window
  function automatic logic [127:0] exp_west(input int t);
    logic [127:0] r = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = ma[i*N + (t - i)];
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_north(input int t);
    logic [127:0] r = '0;
    for (int j = 0; j < N; j++) begin
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = mb[(t - j)*N + j];
    end
    return r;
  endfunction

  task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[addr] = d;
    else     ma[addr] = d;
  endtask

  task automatic load_rand();
    for (int k = 0; k < N*N; k++) wr(1'b0, k, DW'($urandom_range(0, 65535)));
    for (int k = 0; k < N*N; k++) wr(1'b1, k, DW'($urandom_range(0, 65535)));
  endtask

  // Cycle c counts from the start edge: 1 = clear, 2..FL+1 = feed t=c-2, FL+2 = done, FL+3 = idle
  task automatic cyc_check(input string name, input int c);
    logic [2:0]   st;
    logic [127:0] ew = '0;
    logic [127:0] en = '0;
    if (c == 1) st = 3'b100;
    else if (c <= FL + 1) begin
      st = 3'b101;
      ew = exp_west(c - 2);
      en = exp_north(c - 2);
    end else if (c == FL + 2) st = 3'b111;
    else st = 3'b001;
    chk($sformatf("%s status(busy,done,arr_rst_n) c%0d", name, c), {busy, done, arr_rst_n}, st);
    chk($sformatf("%s west c%0d", name, c), wbus(), ew);
    chk($sformatf("%s north c%0d", name, c), nbus(), en);
  endtask

  task automatic run(input string name, input bit inj, input bit same_wr, input logic [DW-1:0] sw_data);
    int done_cnt = 0;
    logic [127:0] wb, nb;
    logic [63:0] acc, ref_v;
    start = 1'b1;
    if (same_wr) begin
      wr_en   = 1'b1;
      wr_sel  = 1'b1;
      wr_addr = 4'd0;
      wr_data = sw_data;
      mb[0]   = sw_data;
    end
    for (int c = 1; c <= FL + 3; c++) begin
      @(negedge clk);
      if (inj && c <= FL + 2) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'($urandom);
        wr_addr = 4'($urandom);
        wr_data = $urandom;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      cyc_check(name, c);
      if (done) done_cnt++;
      if (c >= 2) begin
        wb = wbus();
        nb = nbus();
        for (int i = 0; i < N; i++) begin
          rec_w[i][c-2] = wb[i*DW +: DW];
          rec_n[i][c-2] = nb[i*DW +: DW];
        end
      end
    end
    chk($sformatf("%s done pulses", name), done_cnt, 1);
    // PE(r,c) sees row r's stream delayed c cycles and column c's stream delayed r cycles
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc   = '0;
        ref_v = '0;
        for (int s = 0; s < RL + 2*N; s++) begin
          if (s - c >= 0 && s - c < RL && s - r >= 0 && s - r < RL)
            acc += 64'(rec_w[r][s-c]) * 64'(rec_n[c][s-r]);
        end
        for (int k = 0; k < N; k++) ref_v += 64'(ma[r*N + k]) * 64'(mb[k*N + c]);
        chk($sformatf("%s C[%0d][%0d]", name, r, c), acc, ref_v);
      end
    end
  endtask

  task automatic reset_mid();
    int done_cnt = 0;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      cyc_check("rstmid", c);
    end
    #1 rst = 1'b0;
    #1;
    chk("rstmid async status", {busy, done, arr_rst_n}, 3'b000);
    chk("rstmid async west", wbus(), '0);
    chk("rstmid async north", nbus(), '0);
    for (int k = 0; k < N*N; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    #1 rst = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      chk($sformatf("rstmid idle status c%0d", c), {busy, done, arr_rst_n}, 3'b001);
    end
    chk("rstmid done pulses", done_cnt, 0);
  endtask

  initial begin
    for (int k = 0; k < N*N; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    #1 rst = 1'b0;
    #1;
    chk("reset status", {busy, done, arr_rst_n}, 3'b000);
    chk("reset west", wbus(), '0);
    chk("reset north", nbus(), '0);
    @(posedge clk);
    #1;
    chk("reset held over edge", {busy, done, arr_rst_n}, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    chk("arr_rst_n before first edge", arr_rst_n, 1'b0);
    @(negedge clk);
    chk("arr_rst_n after first edge", {busy, done, arr_rst_n}, 3'b001);

    run("zero", 1'b0, 1'b0, '0);

    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r*N + c, (r == c) ? 32'd1 : 32'd0);
        wr(1'b1, r*N + c, 32'(r*4 + c + 1));
      end
    end
    run("ident", 1'b0, 1'b0, '0);

    wr(1'b0, 15, 32'hDEADBEEF);
    run("beef", 1'b0, 1'b0, '0);

    run("samewr", 1'b0, 1'b1, 32'd7);

    load_rand();
    run("inj", 1'b1, 1'b0, '0);
    run("after_inj", 1'b0, 1'b0, '0);

    for (int n = 0; n < 3; n++) begin
      load_rand();
      run($sformatf("rand%0d", n), 1'b0, 1'b0, '0);
    end

    reset_mid();
    run("post_rst_zero", 1'b0, 1'b0, '0);
    load_rand();
    run("post_rst", 1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4, array dimension (rows = columns).
REQ-002 Parameter DATA_W, default 32, operand width.
REQ-003 Parameter FEED_LEN, default 3*N-2 (10), FEED-state cycles per run.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  operand write strobe.
REQ-007 wr_sel  in  1  target matrix: 0 = A (west operands), 1 = B (north operands).
REQ-008 wr_addr  in  4  element index, row*N+col.
REQ-009 wr_data  in  DATA_W  element value.
REQ-010 start  in  1  single-cycle run request.
REQ-011 busy  out  1  high from the cycle after an accepted start until done inclusive.
REQ-012 done  out  1  one-cycle pulse at run end.
REQ-013 arr_rst_n  out  1  active-low clear to the array, low for exactly one cycle per run.
REQ-014 west0..west3  out  DATA_W each  row-i west operand, to array rows 0..3.
REQ-015 north0..north3  out  DATA_W each  column-j north operand, to array columns 0..3.

Function
REQ-016 Two 16-entry DATA_W buffers SHALL hold A and B; a write with wr_en=1 in IDLE SHALL update entry wr_addr of the selected buffer at the clock edge.
REQ-017 Writes while busy=1 SHALL be dropped with no buffer change.
REQ-018 FSM states SHALL be IDLE, CLEAR, FEED, DONE.
REQ-019 IDLE: start=1 -> CLEAR; start while not IDLE SHALL be ignored.
REQ-020 CLEAR lasts 1 cycle with arr_rst_n=0 registered; -> FEED with step counter t=0.
REQ-021 FEED lasts FEED_LEN cycles, t = 0..FEED_LEN-1; at t=FEED_LEN-1 -> DONE.
REQ-022 In FEED, west_i SHALL equal A[i][t-i] when 0 <= t-i < N, else 0.
REQ-023 In FEED, north_j SHALL equal B[t-j][j] when 0 <= t-j < N, else 0.
REQ-024 west/north outputs SHALL be registered, valid in the same cycle the FSM reports that t; zero in IDLE, CLEAR and DONE.
REQ-025 DONE lasts 1 cycle with done=1, then -> IDLE.
REQ-026 A write and start in the same IDLE cycle: the write SHALL commit and the run SHALL use the written value.
REQ-027 Start-to-done latency SHALL be FEED_LEN+2 cycles after the start edge; the next start is accepted in the cycle after DONE.
REQ-028 Step counter SHALL be $clog2(FEED_LEN) bits wide and SHALL not wrap within a run.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, t=0, busy=0, done=0, arr_rst_n=0, all west/north outputs 0, both buffers 0.
REQ-030 After rst deasserts, arr_rst_n SHALL go 1 on the first clock edge.
REQ-031 Reset mid-run SHALL abort the run with no done pulse.

Structure
REQ-032 Package systolic_pkg SHALL hold N, DATA_W, FEED_LEN defaults and the FSM state enum.
REQ-033 One sub-module, skew_sel, SHALL compute the skewed element select (index and valid) for one lane from t and lane number; 2*N instances.

Verification
REQ-034 A=identity, B[r][c]=r*4+c+1, start -> arr_rst_n low 1 cycle; FEED t=0: west0=1, north0=1, others 0; done exactly 12 cycles after start edge.
REQ-035 A[3][3]=0xDEADBEEF, start -> west3=0xDEADBEEF only at t=6, zero at all other t.
REQ-036 Writes and start during busy -> buffers unchanged, no extra run, single done pulse.
REQ-037 rst pulsed low at FEED t=4 -> all outputs 0 immediately, no done, next start runs normally.
REQ-038 Same-cycle write B[0][0]=7 and start -> north0=7 at t=0.
REQ-039 End-to-end with 4x4 array: A, B random 16-bit values -> array results equal reference A*B after done.
